// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_pkg;

    localparam int unsigned AW_DEFAULT  = 9;
    localparam int unsigned IW_DEFAULT  = 20;
    localparam int unsigned OPW_DEFAULT = 5;

    localparam logic [OPW_DEFAULT-1:0] DONE_OP_DEFAULT = 5'b01110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/instr_ram.sv
// Program store: one write port, one synchronous read port, read-before-write.
module instr_ram
    import ifetch_pkg::*;
#(
    parameter int unsigned AW = AW_DEFAULT,
    parameter int unsigned IW = IW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [IW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [IW-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [IW-1:0] mem [DEPTH];

    // Array is never reset so the program survives rst_n.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking read sees the pre-write word on an address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: sequential PC, branch redirect, halt on DONE_OP.
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter int unsigned    AW      = AW_DEFAULT,
    parameter int unsigned    IW      = IW_DEFAULT,
    parameter int unsigned    OPW     = OPW_DEFAULT,
    parameter logic [OPW-1:0] DONE_OP = OPW'(DONE_OP_DEFAULT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic          stall,
    input  logic          branch_taken,
    input  logic          branch_rel,
    input  logic [AW-1:0] branch_target,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [IW-1:0] prog_data,
    output logic [IW-1:0] inst,
    output logic [AW-1:0] inst_pc,
    output logic          inst_valid,
    output logic          done
);

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] fetch_pc_q;
    logic [AW-1:0] fetch_pc_d;
    logic [AW-1:0] inst_pc_d;
    logic          inst_valid_d;
    logic          done_d;
    logic          rd_en_c;

    logic [OPW-1:0] opcode_c;
    logic           accepted_c;
    logic           accept_done_c;
    logic           take_branch_c;
    logic [AW-1:0]  branch_dest_c;

    // An instruction is consumed when it is live and the consumer is not holding.
    assign opcode_c      = inst[IW-1 -: OPW];
    assign accepted_c    = (state_q == ST_FETCH) && inst_valid && !stall;
    assign accept_done_c = accepted_c && (opcode_c == DONE_OP);
    assign take_branch_c = accepted_c && branch_taken && !accept_done_c;
    assign branch_dest_c = branch_rel ? AW'(inst_pc + branch_target) : branch_target;

    instr_ram #(
        .AW (AW),
        .IW (IW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (prog_we),
        .wr_addr (prog_addr),
        .wr_data (prog_data),
        .rd_en   (rd_en_c),
        .rd_addr (fetch_pc_q),
        .rd_data (inst)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Start overrides everything, including a pending halt.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: if (accept_done_c) state_d = ST_HALT;
                default:  state_d = state_q;
            endcase
        end
    end

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        inst_pc_d    = inst_pc;
        inst_valid_d = inst_valid;
        done_d       = done;
        rd_en_c      = 1'b0;
        if (start) begin
            fetch_pc_d   = start_addr;
            inst_valid_d = 1'b0;
            done_d       = 1'b0;
        end else if (state_q == ST_FETCH && !stall) begin
            if (accept_done_c) begin
                inst_valid_d = 1'b0;
                done_d       = 1'b1;
            end else begin
                rd_en_c   = 1'b1;
                inst_pc_d = fetch_pc_q;
                if (take_branch_c) begin
                    // The word read this cycle is the wrong-path one; squash it.
                    inst_valid_d = 1'b0;
                    fetch_pc_d   = branch_dest_c;
                end else begin
                    inst_valid_d = 1'b1;
                    fetch_pc_d   = fetch_pc_q + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inst_pc    <= inst_pc_d;
            inst_valid <= inst_valid_d;
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector tables, corner sequences, random vs model.
module tb_instr_fetch;

    localparam int unsigned AW = 9;
    localparam int unsigned IW = 20;
    localparam logic [4:0]    DONE_OPC  = 5'b01110;
    localparam logic [IW-1:0] DONE_WORD = 20'h70000;
    localparam logic [IW-1:0] NEW_WORD  = 20'h2ABCD;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] start_addr;
    logic          stall;
    logic          branch_taken;
    logic          branch_rel;
    logic [AW-1:0] branch_target;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [IW-1:0] prog_data;
    logic [IW-1:0] inst;
    logic [AW-1:0] inst_pc;
    logic          inst_valid;
    logic          done;

    int n_checks = 0;
    int n_err    = 0;

    instr_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .start_addr    (start_addr),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_rel    (branch_rel),
        .branch_target (branch_target),
        .prog_we       (prog_we),
        .prog_addr     (prog_addr),
        .prog_data     (prog_data),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_valid    (inst_valid),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          start;
        logic [AW-1:0] saddr;
        logic          stall;
        logic          br;
        logic          rel;
        logic [AW-1:0] tgt;
        logic          ev;
        logic [AW-1:0] epc;
        logic [IW-1:0] einst;
        logic          edone;
    } vec_t;

    vec_t vecs[$];

    // Behavioural reference: program image plus architectural fetch state.
    logic [IW-1:0] mdl_mem [512];
    bit            m_run;
    bit            m_valid;
    bit            m_done;
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_ipc;
    logic [IW-1:0] m_inst;

    function automatic logic [IW-1:0] w(input int i);
        return 20'h10000 | IW'(i & 32'h1FF);
    endfunction

    function automatic vec_t mk(input logic st, input logic [AW-1:0] sa, input logic sl,
                                input logic br, input logic rel, input logic [AW-1:0] tg,
                                input logic ev, input logic [AW-1:0] epc,
                                input logic [IW-1:0] ei, input logic ed);
        vec_t v;
        v.start = st; v.saddr = sa; v.stall = sl; v.br = br; v.rel = rel; v.tgt = tg;
        v.ev = ev; v.epc = epc; v.einst = ei; v.edone = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        start         = 1'b0;
        start_addr    = '0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_rel    = 1'b0;
        branch_target = '0;
        prog_we       = 1'b0;
        prog_addr     = '0;
        prog_data     = '0;
    endtask

    task automatic prog_write(input logic [AW-1:0] a, input logic [IW-1:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        mdl_mem[a] = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            start         = vecs[i].start;
            start_addr    = vecs[i].saddr;
            stall         = vecs[i].stall;
            branch_taken  = vecs[i].br;
            branch_rel    = vecs[i].rel;
            branch_target = vecs[i].tgt;
            tick();
            check($sformatf("%s[%0d].valid", tag, i), 32'(inst_valid), 32'(vecs[i].ev));
            check($sformatf("%s[%0d].done", tag, i), 32'(done), 32'(vecs[i].edone));
            if (vecs[i].ev) begin
                check($sformatf("%s[%0d].pc", tag, i), 32'(inst_pc), 32'(vecs[i].epc));
                check($sformatf("%s[%0d].inst", tag, i), 32'(inst), 32'(vecs[i].einst));
            end
        end
        vecs.delete();
        drive_idle();
    endtask

    // One clock of the reference, evaluated on the inputs present before the edge.
    task automatic model_step();
        logic [AW-1:0] old_ipc;
        bit            br_ok;
        if (start) begin
            m_run   = 1'b1;
            m_pc    = start_addr;
            m_valid = 1'b0;
            m_done  = 1'b0;
        end else if (m_run && !stall) begin
            if (m_valid && m_inst[IW-1 -: 5] == DONE_OPC) begin
                m_run   = 1'b0;
                m_valid = 1'b0;
                m_done  = 1'b1;
            end else begin
                old_ipc = m_ipc;
                br_ok   = m_valid && branch_taken;
                m_inst  = mdl_mem[m_pc];
                m_ipc   = m_pc;
                if (br_ok) begin
                    m_valid = 1'b0;
                    m_pc    = branch_rel ? AW'(old_ipc + branch_target) : branch_target;
                end else begin
                    m_valid = 1'b1;
                    m_pc    = AW'(m_pc + 1);
                end
            end
        end
        if (prog_we) mdl_mem[prog_addr] = prog_data;
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        #3;
        check("reset.inst", 32'(inst), 32'h0);
        check("reset.pc", 32'(inst_pc), 32'h0);
        check("reset.valid", 32'(inst_valid), 32'h0);
        check("reset.done", 32'(done), 32'h0);
        #4;
        rst_n = 1'b1;

        for (int i = 0; i < 512; i++) prog_write(AW'(i), w(i));
        prog_write(9'd4, DONE_WORD);

        // Straight-line run into a halt; early branch (not valid) and branch beside DONE are ignored.
        vecs.push_back(mk(1, 9'd0, 0, 0, 0, 9'd0,   0, 9'd0, '0,        0));
        vecs.push_back(mk(0, 9'd0, 0, 1, 0, 9'h050, 1, 9'd0, w(0),      0));
        vecs.push_back(mk(0, 9'd0, 0, 0, 0, 9'd0,   1, 9'd1, w(1),      0));
        vecs.push_back(mk(0, 9'd0, 0, 0, 0, 9'd0,   1, 9'd2, w(2),      0));
        vecs.push_back(mk(0, 9'd0, 0, 0, 0, 9'd0,   1, 9'd3, w(3),      0));
        vecs.push_back(mk(0, 9'd0, 0, 0, 0, 9'd0,   1, 9'd4, DONE_WORD, 0));
        vecs.push_back(mk(0, 9'd0, 0, 1, 0, 9'h050, 0, 9'd0, '0,        1));
        vecs.push_back(mk(0, 9'd0, 0, 0, 0, 9'd0,   0, 9'd0, '0,        1));
        run_vecs("halt");

        prog_write(9'd4, w(4));

        // Stall hold, relative and absolute branches, branch under stall, PC wrap.
        vecs.push_back(mk(1, 9'd0,   0, 0, 0, 9'd0,   0, 9'd0,   '0,        0));
        vecs.push_back(mk(0, 9'd0,   0, 0, 0, 9'd0,   1, 9'd0,   w(0),      0));
        vecs.push_back(mk(0, 9'd0,   0, 0, 0, 9'd0,   1, 9'd1,   w(1),      0));
        vecs.push_back(mk(0, 9'd0,   0, 0, 0, 9'd0,   1, 9'd2,   w(2),      0));
        vecs.push_back(mk(0, 9'd0,   1, 0, 0, 9'd0,   1, 9'd2,   w(2),      0));
        vecs.push_back(mk(0, 9'd0,   1, 0, 0, 9'd0,   1, 9'd2,   w(2),      0));
        vecs.push_back(mk(0, 9'd0,   1, 0, 0, 9'd0,   1, 9'd2,   w(2),      0));
        vecs.push_back(mk(0, 9'd0,   0, 0, 0, 9'd0,   1, 9'd3,   w(3),      0));
        vecs.push_back(mk(0, 9'd0,   0, 0, 0, 9'd0,   1, 9'd4,   w(4),      0));
        vecs.push_back(mk(0, 9'd0,   0, 0, 0, 9'd0,   1, 9'd5,   w(5),      0));
        vecs.push_back(mk(0, 9'd0,   0, 1, 1, 9'h1FD, 0, 9'd0,   '0,        0));
        vecs.push_back(mk(0, 9'd0,   0, 0, 0, 9'd0,   1, 9'd2,   w(2),      0));
        vecs.push_back(mk(0, 9'd0,   0, 0, 0, 9'd0,   1, 9'd3,   w(3),      0));
        vecs.push_back(mk(0, 9'd0,   0, 1, 0, 9'h100, 0, 9'd0,   '0,        0));
        vecs.push_back(mk(0, 9'd0,   0, 0, 0, 9'd0,   1, 9'h100, w(9'h100), 0));
        vecs.push_back(mk(0, 9'd0,   1, 1, 0, 9'h020, 1, 9'h100, w(9'h100), 0));
        vecs.push_back(mk(0, 9'd0,   0, 0, 0, 9'd0,   1, 9'h101, w(9'h101), 0));
        vecs.push_back(mk(1, 9'h1FF, 0, 0, 0, 9'd0,   0, 9'd0,   '0,        0));
        vecs.push_back(mk(0, 9'd0,   0, 0, 0, 9'd0,   1, 9'h1FF, w(9'h1FF), 0));
        vecs.push_back(mk(0, 9'd0,   0, 0, 0, 9'd0,   1, 9'd0,   w(0),      0));
        vecs.push_back(mk(0, 9'd0,   0, 0, 0, 9'd0,   1, 9'd1,   w(1),      0));
        run_vecs("flow");

        // Write and fetch of address 7 in the same cycle.
        start = 1'b1; start_addr = 9'd7;
        tick();
        start = 1'b0;
        check("rbw.squash", 32'(inst_valid), 32'h0);
        prog_we = 1'b1; prog_addr = 9'd7; prog_data = NEW_WORD;
        mdl_mem[7] = NEW_WORD;
        tick();
        prog_we = 1'b0;
        check("rbw.old_pc", 32'(inst_pc), 32'd7);
        check("rbw.old_inst", 32'(inst), 32'(w(7)));
        start = 1'b1; start_addr = 9'd7;
        tick();
        start = 1'b0;
        tick();
        check("rbw.new_valid", 32'(inst_valid), 32'h1);
        check("rbw.new_inst", 32'(inst), 32'(NEW_WORD));

        // Asynchronous reset in the middle of a fetch run.
        tick();
        #1 rst_n = 1'b0;
        #1;
        check("areset.inst", 32'(inst), 32'h0);
        check("areset.pc", 32'(inst_pc), 32'h0);
        check("areset.valid", 32'(inst_valid), 32'h0);
        check("areset.done", 32'(done), 32'h0);
        #1 rst_n = 1'b1;
        start = 1'b1; start_addr = 9'd3;
        tick();
        start = 1'b0;
        check("areset.start_valid", 32'(inst_valid), 32'h0);
        tick();
        check("areset.pc3", 32'(inst_pc), 32'd3);
        check("areset.mem3", 32'(inst), 32'(w(3)));

        // Random traffic from a clean reset against the reference.
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        m_run = 1'b0; m_valid = 1'b0; m_done = 1'b0;
        m_pc = '0; m_ipc = '0; m_inst = '0;
        for (int c = 0; c < 2000; c++) begin
            start         = ($urandom_range(31) == 0);
            start_addr    = AW'($urandom);
            stall         = ($urandom_range(3) == 0);
            branch_taken  = ($urandom_range(5) == 0);
            branch_rel    = 1'($urandom_range(1));
            branch_target = AW'($urandom);
            prog_we       = ($urandom_range(7) == 0);
            prog_addr     = AW'($urandom);
            prog_data     = ($urandom_range(3) == 0) ? DONE_WORD : IW'($urandom);
            model_step();
            tick();
            check($sformatf("rnd[%0d].valid", c), 32'(inst_valid), 32'(m_valid));
            check($sformatf("rnd[%0d].done", c), 32'(done), 32'(m_done));
            if (m_valid) begin
                check($sformatf("rnd[%0d].pc", c), 32'(inst_pc), 32'(m_ipc));
                check($sformatf("rnd[%0d].inst", c), 32'(inst), 32'(m_inst));
            end
        end
        drive_idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter AW, default 9: instruction address width; depth is 2**AW.
REQ-002 Parameter IW, default 20: instruction width.
REQ-003 Parameter OPW, default 5: opcode field width, located at Inst[IW-1 -: OPW].
REQ-004 Parameter DONE_OP, default 5'b01110: opcode that halts fetch.
REQ-005 Clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 Reset_n  in  1  asynchronous, active-low reset.
REQ-007 Start  in  1  one-cycle pulse; begin or restart fetch at StartAddr.
REQ-008 StartAddr  in  AW  first fetch address.
REQ-009 Stall  in  1  consumer hold; freezes PC, Inst, InstValid and state.
REQ-010 BranchTaken  in  1  redirect request; qualified only when InstValid=1 and Stall=0.
REQ-011 BranchRel  in  1  1 = target is InstPc + signed BranchTarget; 0 = absolute.
REQ-012 BranchTarget  in  AW  absolute address or two's-complement offset.
REQ-013 ProgWe  in  1  program-store write enable.
REQ-014 ProgAddr  in  AW  write address.
REQ-015 ProgData  in  IW  write data.
REQ-016 Inst  out  IW  registered fetched instruction.
REQ-017 InstPc  out  AW  address of Inst.
REQ-018 InstValid  out  1  Inst is live, not squashed.
REQ-019 Done  out  1  DONE_OP retired; held until the next Start.

Function
REQ-020 FSM states: IDLE, FETCH, HALT.
- IDLE --Start--> FETCH
- FETCH --DONE_OP accepted--> HALT
- HALT --Start--> FETCH
REQ-021 Start in any state, stalled or not: FetchPc<=StartAddr, InstValid<=0, Done<=0, state<=FETCH; Start has priority over Stall, branch and done.
REQ-022 In FETCH with Stall=0: Inst<=mem[FetchPc], InstPc<=FetchPc, InstValid<=1, FetchPc<=FetchPc+1 mod 2**AW; first instruction appears 1 cycle after Start.
REQ-023 PC wrap-around: FetchPc=2**AW-1 increments to 0, with no flag.
REQ-024 Qualified branch: FetchPc<=target; the instruction read in the same cycle is squashed (InstValid=0 next cycle); the target instruction appears 2 cycles after the branch cycle.
REQ-025 Relative target = InstPc + sign-extended BranchTarget, truncated to AW bits (wraps).
REQ-026 Opcode DONE_OP with InstValid=1 and Stall=0: that cycle counts as accepted; next cycle state=HALT, InstValid=0, Done=1; a branch asserted on the same cycle is ignored.
REQ-027 In IDLE and HALT no reads occur, InstValid=0, and FetchPc holds.
REQ-028 Program writes are accepted in every state, including while stalled.
REQ-029 A same-cycle write and fetch to the same address returns the old data (read-before-write).
REQ-030 BranchTaken with InstValid=0 or Stall=1 is ignored.

Reset
REQ-031 Reset_n low asynchronously forces: state=IDLE, FetchPc=0, Inst=0, InstPc=0, InstValid=0, Done=0.
REQ-032 Reset does not clear program-store contents.
REQ-033 Reset mid-fetch abandons the in-flight read; the first post-reset Start behaves as from power-up.

Structure
REQ-034 Shared package ifetch_pkg holds:
- state enum
- DONE_OP and opcode-field constants
- default AW/IW values
REQ-035 Program store is sub-module instr_ram: 1 write port and 1 synchronous read port, read-before-write, parametrised by AW and IW; instr_fetch holds the FSM, PC and branch logic.

Verification
REQ-036 Scenario: load addrs 0..3 with distinct words, addr 4 with DONE_OP; Start at 0.
- Response: Inst 0..4 on consecutive cycles with InstPc 0..4.
- Then InstValid=0 and Done=1 one cycle after addr 4.
REQ-037 Scenario: Stall high for 3 cycles while InstPc=2 → Inst and InstPc hold at 2 for those 3 cycles, then resume with 3.
REQ-038 Scenario: relative branch, offset 9'h1FD, at InstPc=5.
- Response: one squashed cycle, then InstPc=2.
- Scenario: absolute branch to 0x100 → InstPc=0x100 after one squashed cycle.
REQ-039 Scenario: AW=4, Start at 15 with no DONE_OP → InstPc sequence 15, 0, 1.
REQ-040 Scenario: ProgWe to addr 7 in the same cycle the fetch reads addr 7 → old word delivered; a refetch after re-Start delivers the new word.
REQ-041 Scenario: Reset_n pulsed low mid-FETCH → outputs zero immediately, without waiting for a clock edge.
- Then Start at 3 delivers mem[3] one cycle later.
